// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage control types: FSM state, bubble instruction and IF/ID word.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_HOLD     = 2'd3
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            oImemReq;
  logic [XLEN-1:0] oImemAddr;
  logic            iImemRdy;
  logic [XLEN-1:0] iImemData;

  modport master (
    output oImemReq,
    output oImemAddr,
    input  iImemRdy,
    input  iImemData
  );

  modport slave (
    input  oImemReq,
    input  oImemAddr,
    output iImemRdy,
    output iImemData
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on decode stall, loads a word or a bubble otherwise.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iStall,
  input  logic            iLoad,
  input  fetch_word_t     iWord,
  output logic [XLEN-1:0] oInstr,
  output logic [XLEN-1:0] oPc,
  output logic [XLEN-1:0] oPcPlus4,
  output logic            oValid
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Next contents: frozen on stall, else the delivered word or a bubble.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!iStall) begin
      if (iLoad) begin
        instr_d = iWord.instr;
        pc_d    = iWord.pc;
        pc4_d   = iWord.pc + XLEN'(4);
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  // Register state; reset presents a bubble.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign oInstr   = instr_q;
  assign oPc      = pc_q;
  assign oPcPlus4 = pc4_q;
  assign oValid   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request FSM, redirect squash and hold buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic               iStallF,
  input  logic               iStallD,
  input  logic               iBranchTakenD,
  input  logic [XLEN-1:0]    iBranchTargetD,
  fetch_stage_if.master      imem,
  output logic [XLEN-1:0]    oInstrD,
  output logic [XLEN-1:0]    oPcD,
  output logic [XLEN-1:0]    oPcPlus4D,
  output logic               oValidD
);

  localparam logic [XLEN-1:0] PC_RESET = RESET_PC & ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            squash_q, squash_d;
  fetch_word_t     hold_q, hold_d;

  logic            imem_req_c;
  logic            redirect_c;
  logic [XLEN-1:0] redirect_pc_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic            ifid_load_c;
  fetch_word_t     ifid_word_c;
  fetch_word_t     resp_word_c;

  // Next-state, PC and IF/ID control; redirects only count when decode is not stalled.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    tgt_d         = tgt_q;
    squash_d      = squash_q;
    hold_d        = hold_q;
    imem_req_c    = 1'b0;
    ifid_load_c   = 1'b0;
    redirect_c    = iBranchTakenD & ~iStallD;
    redirect_pc_c = align_word(iBranchTargetD);
    pc_plus4_c    = pc_q + XLEN'(4);
    resp_word_c   = '{instr: imem.iImemData, pc: pc_q};
    ifid_word_c   = resp_word_c;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect_c) pc_d = redirect_pc_c;
      end

      ST_FETCH: begin
        if (iStallF) begin
          if (redirect_c) pc_d = redirect_pc_c;
        end else begin
          imem_req_c = 1'b1;
          if (imem.iImemRdy) begin
            if (redirect_c) begin
              pc_d = redirect_pc_c;
            end else begin
              pc_d = pc_plus4_c;
              if (iStallD) begin
                hold_d  = resp_word_c;
                state_d = ST_HOLD;
              end else begin
                ifid_load_c = 1'b1;
              end
            end
          end else begin
            // Request is committed; a redirect now must wait for its response.
            state_d = ST_WAIT_MEM;
            if (redirect_c) begin
              tgt_d    = redirect_pc_c;
              squash_d = 1'b1;
            end
          end
        end
      end

      ST_WAIT_MEM: begin
        imem_req_c = 1'b1;
        if (imem.iImemRdy) begin
          state_d  = ST_FETCH;
          squash_d = 1'b0;
          if (redirect_c) begin
            pc_d = redirect_pc_c;
          end else if (squash_q) begin
            pc_d = tgt_q;
          end else begin
            pc_d = pc_plus4_c;
            if (iStallD) begin
              hold_d  = resp_word_c;
              state_d = ST_HOLD;
            end else begin
              ifid_load_c = 1'b1;
            end
          end
        end else if (redirect_c) begin
          tgt_d    = redirect_pc_c;
          squash_d = 1'b1;
        end
      end

      ST_HOLD: begin
        ifid_word_c = hold_q;
        if (!iStallD) begin
          state_d = ST_FETCH;
          hold_d  = '0;
          if (redirect_c) begin
            pc_d = redirect_pc_c;
          end else begin
            ifid_load_c = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fetch control state.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_RESET;
      tgt_q    <= '0;
      squash_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      squash_q <= squash_d;
      hold_q   <= hold_d;
    end
  end

  // Request decodes directly from state so reset drops it at once.
  assign imem.oImemReq  = imem_req_c;
  assign imem.oImemAddr = pc_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iStall   (iStallD),
    .iLoad    (ifid_load_c),
    .iWord    (ifid_word_c),
    .oInstr   (oInstrD),
    .oPc      (oPcD),
    .oPcPlus4 (oPcPlus4D),
    .oValid   (oValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stall/redirect/reset sequences.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, stall_f, stall_d, br, rdy;
  logic [31:0] tgt;
  logic        rstn2, rdy2;

  logic [31:0] instr_d, pc_d, pc4_d;
  logic        valid_d;
  logic [31:0] instr_d2, pc_d2, pc4_d2;
  logic        valid_d2;

  int n_chk = 0;
  int n_err = 0;
  int bub   = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  assign bus.iImemRdy   = rdy;
  assign bus.iImemData  = mem_word(bus.oImemAddr);
  assign bus2.iImemRdy  = rdy2;
  assign bus2.iImemData = mem_word(bus2.oImemAddr);

  fetch_stage u_dut (
    .iClk           (clk),
    .iRstN          (rstn),
    .iStallF        (stall_f),
    .iStallD        (stall_d),
    .iBranchTakenD  (br),
    .iBranchTargetD (tgt),
    .imem           (bus),
    .oInstrD        (instr_d),
    .oPcD           (pc_d),
    .oPcPlus4D      (pc4_d),
    .oValidD        (valid_d)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .iClk           (clk),
    .iRstN          (rstn2),
    .iStallF        (1'b0),
    .iStallD        (1'b0),
    .iBranchTakenD  (1'b0),
    .iBranchTargetD (32'h0),
    .imem           (bus2),
    .oInstrD        (instr_d2),
    .oPcD           (pc_d2),
    .oPcPlus4D      (pc4_d2),
    .oValidD        (valid_d2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to 4 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #4;
  endtask

  // Monitor: every edge with decode not stalled loads IF/ID; pop and compare real words.
  logic sd_s, rs_s;
  logic [31:0] exp_pc;
  always begin
    @(posedge clk);
    sd_s = stall_d;
    rs_s = rstn;
    #2;
    if (rs_s && !sd_s) begin
      if (valid_d) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected: got pc %h expected no instruction", pc_d);
        end else begin
          exp_pc = sb.pop_front();
          chk("ifid_pc", pc_d, exp_pc);
          chk("ifid_instr", instr_d, mem_word(exp_pc));
          chk("ifid_pc4", pc4_d, exp_pc + 32'd4);
        end
      end else begin
        bub++;
        chk("bubble_instr", instr_d, NOP);
      end
    end
  end

  initial begin
    rstn = 1'b0; rdy = 1'b1; stall_f = 1'b0; stall_d = 1'b0; br = 1'b0; tgt = '0;
    rstn2 = 1'b0; rdy2 = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_req", 32'(bus.oImemReq), 32'd0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pcd", pc_d, 32'd0);
    chk("rst_pc4", pc4_d, 32'd0);
    chk("rst_valid", 32'(valid_d), 32'd0);
    rstn = 1'b1;

    // Zero-wait streaming: 0,4,8 on consecutive cycles
    step();
    chk("addr0", bus.oImemAddr, 32'h0);
    chk("req0", 32'(bus.oImemReq), 32'd1);
    sb.push_back(32'h0);
    step();
    chk("addr4", bus.oImemAddr, 32'h4);
    sb.push_back(32'h4);
    step();
    chk("addr8", bus.oImemAddr, 32'h8);
    sb.push_back(32'h8);

    // Memory not ready for three cycles on address 8
    rdy = 1'b0;
    bub = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_addr8", bus.oImemAddr, 32'h8);
      chk("wait_req", 32'(bus.oImemReq), 32'd1);
    end
    chk("wait_bubbles", 32'(bub), 32'd3);
    rdy = 1'b1;
    step();

    // Stall around the response of address 12
    rdy = 1'b0; stall_d = 1'b1;
    step();
    chk("frz_pcd_a", pc_d, 32'h8);
    rdy = 1'b1; stall_f = 1'b1;
    step();
    chk("hold_req", 32'(bus.oImemReq), 32'd0);
    chk("frz_pcd_b", pc_d, 32'h8);
    chk("frz_instr", instr_d, mem_word(32'h8));
    step();
    chk("frz_valid", 32'(valid_d), 32'd1);
    stall_f = 1'b0; stall_d = 1'b0;
    sb.push_back(32'hC);
    step();
    chk("after_hold_addr", bus.oImemAddr, 32'h10);

    // Redirect while waiting on address 16
    rdy = 1'b0;
    bub = 0;
    step();
    br = 1'b1; tgt = 32'h0000_0103;
    step();
    br = 1'b0;
    chk("squash_addr_stable", bus.oImemAddr, 32'h10);
    rdy = 1'b1;
    step();
    chk("redirect_addr", bus.oImemAddr, 32'h100);
    chk("redirect_bubbles", 32'(bub), 32'd3);
    sb.push_back(32'h100);
    step();
    chk("addr104", bus.oImemAddr, 32'h104);

    // Redirect coinciding with a zero-wait response
    br = 1'b1; tgt = 32'h200;
    step();
    br = 1'b0;
    chk("same_cycle_addr", bus.oImemAddr, 32'h200);
    sb.push_back(32'h200);
    step();

    // Branch ignored under decode stall, then redirect out of HOLD
    stall_d = 1'b1; br = 1'b1; tgt = 32'h400;
    step();
    chk("hold2_req", 32'(bus.oImemReq), 32'd0);
    chk("hold2_pcd", pc_d, 32'h200);
    stall_d = 1'b0; tgt = 32'h300;
    step();
    br = 1'b0;
    chk("hold_redirect_addr", bus.oImemAddr, 32'h300);
    sb.push_back(32'h300);
    step();

    // Fetch stall in FETCH drops the request and holds PC
    stall_f = 1'b1;
    #1;
    chk("stallf_req", 32'(bus.oImemReq), 32'd0);
    step();
    chk("stallf_addr", bus.oImemAddr, 32'h304);
    stall_f = 1'b0;
    #1;
    chk("stallf_rel_req", 32'(bus.oImemReq), 32'd1);
    sb.push_back(32'h304);
    step();
    stall_f = 1'b1; rdy = 1'b0;
    step();
    step();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    // PC wrap and mid-wait reset on the second instance
    rdy2 = 1'b1; rstn2 = 1'b1;
    step();
    chk("wrap_addr0", bus2.oImemAddr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", bus2.oImemAddr, 32'h0);
    chk("wrap_pcd", pc_d2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_d2, 32'h0);
    chk("wrap_valid", 32'(valid_d2), 32'd1);
    rdy2 = 1'b0;
    step();
    chk("wait2_req", 32'(bus2.oImemReq), 32'd1);
    #1;
    rstn2 = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus2.oImemReq), 32'd0);
    chk("rst_mid_valid", 32'(valid_d2), 32'd0);
    chk("rst_mid_instr", instr_d2, NOP);
    rdy2 = 1'b1;
    step();
    rstn2 = 1'b1;
    step();
    chk("rst_idle_valid", 32'(valid_d2), 32'd0);
    chk("restart_addr", bus2.oImemAddr, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
